load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The block SHALL have port req, input, 1 bit: CPU access request, sampled only in IDLE.
REQ-004 The block SHALL have port op, input, 3 bits: access type.
  - 000 LB, 001 LH, 010 LW, 011 SB
  - 100 LBU, 101 LHU, 110 SH, 111 SW
REQ-005 The block SHALL have port addr, input, 32 bits: byte address of the access.
REQ-006 The block SHALL have port store_data, input, 32 bits: store operand; SB uses bits [7:0], SH uses bits [15:0].
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port err, output, 1 bit: one-cycle misalignment pulse, coincident with done.
REQ-010 The block SHALL have port load_data, output, 32 bits: extended load result.
REQ-011 The block SHALL have port mem_addr, output, 32 bits: word-aligned address, equal to {addr[31:2],2'b00}.
REQ-012 The block SHALL have ports mem_rd and mem_wr, outputs, 1 bit each: memory strobes.
REQ-013 The block SHALL have port mem_wr_data, output, 32 bits: write word.
REQ-014 The block SHALL have port mem_rd_data, input, 32 bits: combinational read word, big-endian; byte offset 0 is bits [31:24].

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RD, WR and DONE.
REQ-016 In IDLE with req=1, the block SHALL latch op, addr and store_data, then go to:
  - DONE with err set, if the access is misaligned
  - RD, for any load or for SB/SH
  - WR, for SW
REQ-017 Misalignment SHALL be defined as:
  - LH, LHU or SH with addr[0]=1
  - LW or SW with addr[1:0] not equal to 00
  - byte accesses are never misaligned
REQ-018 In RD, mem_rd SHALL be 1 for exactly one cycle, and the block SHALL capture mem_rd_data at the end of that cycle.
REQ-019 From RD, the block SHALL go to DONE for loads and to WR for SB/SH.
REQ-020 In WR, mem_wr SHALL be 1 for exactly one cycle, then the FSM SHALL go to DONE.
  - SW: mem_wr_data = store_data
  - SB/SH: mem_wr_data = captured word with only the addressed byte or halfword replaced, all other bytes unchanged
REQ-021 mem_rd and mem_wr SHALL never be 1 in the same cycle.
REQ-022 Both strobes SHALL be 0 in IDLE and in DONE.
REQ-023 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-024 req SHALL be ignored in RD, WR and DONE, so the earliest back-to-back request is accepted in the IDLE cycle after DONE.
REQ-025 Byte selection SHALL be big-endian.
  - Byte offset k selects bits [31-8k : 24-8k].
  - Halfword offset 0 selects bits [31:16]; offset 2 selects bits [15:0].
REQ-026 Load extension SHALL be:
  - LB and LH: sign-extended to 32 bits
  - LBU and LHU: zero-extended to 32 bits
  - LW: the word unchanged
REQ-027 load_data SHALL update only when a load reaches DONE and SHALL hold its value otherwise, including across stores and errors.
REQ-028 Latency from the req-accept edge to done SHALL be:
  - loads: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - misaligned access: 1 cycle
REQ-029 A misaligned access SHALL assert neither mem_rd nor mem_wr and SHALL NOT change load_data.
REQ-030 mem_addr SHALL be driven from the latched address while busy and from the live addr input in IDLE.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE, and the block SHALL immediately drive, without waiting for clk:
  - busy=0, done=0, err=0
  - mem_rd=0, mem_wr=0
  - load_data=0, mem_wr_data=0
  - mem_addr=0 and all latched request registers 0
REQ-032 Reset asserted in RD or WR SHALL abort the access, and no further memory write SHALL occur.
  - An SB/SH aborted in RD leaves memory unchanged.
REQ-033 After rst deasserts, the first rising edge of clk SHALL treat req as a new request from IDLE.

Verification
REQ-034 LW test: memory word at 0x10 = 0x8081_7F01; LW addr=0x10 -> done on the 2nd edge after accept, load_data=0x8081_7F01, mem_rd high for exactly 1 cycle.
REQ-035 Byte-load test: same memory word; LB addr=0x11 -> load_data=0xFFFF_FF81; LBU addr=0x11 -> 0x0000_0081; LH addr=0x12 -> 0x0000_7F01.
REQ-036 SB read-modify-write test: SB addr=0x12, store_data=0xAA -> mem_rd in cycle 1, mem_wr in cycle 2 with mem_wr_data=0x8081_AA01, done in cycle 3, load_data unchanged.
REQ-037 Misaligned test: LW addr=0x13 -> done=1 and err=1 one cycle after accept, no strobe asserted; SH addr=0x11 -> same response.
REQ-038 Reset-abort test: SH addr=0x10 with rst pulsed during RD -> strobes drop to 0 asynchronously, no mem_wr ever occurs, memory word unchanged, busy=0.
REQ-039 Back-to-back test: req held high through an LW followed by an SW -> the second request is accepted only in IDLE after DONE, and mem_rd/mem_wr are never high together.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request and memory port bundle for the load/store unit
interface load_store_unit_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    modport slave (
        input  req, op, addr, store_data, mem_rd_data,
        output busy, done, err, load_data, mem_addr, mem_rd, mem_wr, mem_wr_data
    );

    modport master (
        output req, op, addr, store_data, mem_rd_data,
        input  busy, done, err, load_data, mem_addr, mem_rd, mem_wr, mem_wr_data
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - big-endian load/store unit with read-modify-write sub-word stores
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [31:0] r_rd_word;
    logic [31:0] r_load_data;
    logic        r_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_merge;
    logic        w_accept_misaligned;

    function automatic logic f_is_store(input logic [2:0] op);
        f_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: f_misaligned = off[0];
            OP_LW, OP_SW:         f_misaligned = (off != 2'b00);
            default:              f_misaligned = 1'b0;
        endcase
    endfunction

    assign w_accept_misaligned = f_misaligned(bus.op, bus.addr[1:0]);

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: misaligned requests skip memory, SW writes directly, SB/SH read first
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_accept_misaligned) begin
                        w_next = S_DONE;
                    end else if (bus.op == OP_SW) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:    w_next = f_is_store(r_op) ? S_WR : S_DONE;
            S_WR:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch, read-word capture and load result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= 3'b000;
            r_addr       <= 32'h0;
            r_store_data <= 32'h0;
            r_rd_word    <= 32'h0;
            r_load_data  <= 32'h0;
            r_err        <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.req) begin
                r_op         <= bus.op;
                r_addr       <= bus.addr;
                r_store_data <= bus.store_data;
                r_err        <= w_accept_misaligned;
            end
            if (r_state == S_RD) begin
                r_rd_word <= bus.mem_rd_data;
                if (!f_is_store(r_op)) begin
                    r_load_data <= w_load_ext;
                end
            end
        end
    end

    // Big-endian lane select and sign/zero extension of the word being read
    always_comb begin
        w_byte     = 8'h00;
        w_half     = 16'h0000;
        w_load_ext = bus.mem_rd_data;
        case (r_addr[1:0])
            2'd0:    w_byte = bus.mem_rd_data[31:24];
            2'd1:    w_byte = bus.mem_rd_data[23:16];
            2'd2:    w_byte = bus.mem_rd_data[15:8];
            default: w_byte = bus.mem_rd_data[7:0];
        endcase
        w_half = r_addr[1] ? bus.mem_rd_data[15:0] : bus.mem_rd_data[31:16];
        case (r_op)
            OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_ext = {24'h0, w_byte};
            OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = bus.mem_rd_data;
        endcase
    end

    // Write word: SW passes the operand, SB/SH patch one lane of the captured word
    always_comb begin
        w_merge = r_rd_word;
        case (r_op)
            OP_SB: begin
                case (r_addr[1:0])
                    2'd0:    w_merge[31:24] = r_store_data[7:0];
                    2'd1:    w_merge[23:16] = r_store_data[7:0];
                    2'd2:    w_merge[15:8]  = r_store_data[7:0];
                    default: w_merge[7:0]   = r_store_data[7:0];
                endcase
            end
            OP_SH: begin
                if (r_addr[1]) begin
                    w_merge[15:0] = r_store_data[15:0];
                end else begin
                    w_merge[31:16] = r_store_data[15:0];
                end
            end
            OP_SW:   w_merge = r_store_data;
            default: w_merge = r_rd_word;
        endcase
    end

    // Outputs decoded from state; mem_addr is forced to zero while reset is held
    always_comb begin
        bus.busy        = (r_state != S_IDLE);
        bus.done        = (r_state == S_DONE);
        bus.err         = (r_state == S_DONE) && r_err;
        bus.mem_rd      = (r_state == S_RD);
        bus.mem_wr      = (r_state == S_WR);
        bus.mem_wr_data = (r_state == S_WR) ? w_merge : 32'h0;
        bus.load_data   = r_load_data;
        if (rst) begin
            bus.mem_addr = 32'h0;
        end else if (r_state != S_IDLE) begin
            bus.mem_addr = {r_addr[31:2], 2'b00};
        end else begin
            bus.mem_addr = {bus.addr[31:2], 2'b00};
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk;
    logic        rst;
    logic        mem_load;
    logic [31:0] mem      [16];
    logic [31:0] seed_mem [16];
    logic [31:0] ref_mem  [16];
    logic [31:0] ref_ld;
    int          n_vec;
    int          n_miss;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rd_data = mem[bus.mem_addr[5:2]];

    // Bench memory: preloaded from the seed image, written by the DUT strobe
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= seed_mem[i];
        end else if (bus.mem_wr) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: expected response of one access, updating model memory and load result
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         output logic e, output int lat, output int nrd, output int nwr,
                         output logic [31:0] wdat);
        int          k;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;
        bit          is_st;
        bit          half;
        bit          word;
        k     = int'(a[1:0]);
        w     = ref_mem[a[5:2]];
        is_st = (o == 3) || (o == 6) || (o == 7);
        half  = (o == 1) || (o == 5) || (o == 6);
        word  = (o == 2) || (o == 7);
        e     = (half && a[0]) || (word && (a[1:0] != 0));
        wdat  = 32'h0;
        if (e) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (!is_st) begin
            lat = 2; nrd = 1; nwr = 0;
            case (o)
                3'd0, 3'd4: begin
                    v = (w >> (8 * (3 - k))) & 32'hFF;
                    if (o == 0 && (v & 32'h80) != 0) v = v | 32'hFFFF_FF00;
                end
                3'd1, 3'd5: begin
                    v = (w >> (8 * (2 - k))) & 32'hFFFF;
                    if (o == 1 && (v & 32'h8000) != 0) v = v | 32'hFFFF_0000;
                end
                default: v = w;
            endcase
            ref_ld = v;
        end else if (o == 7) begin
            lat = 2; nrd = 0; nwr = 1;
            wdat = d;
            ref_mem[a[5:2]] = d;
        end else begin
            lat = 3; nrd = 1; nwr = 1;
            if (o == 3) begin
                mask = 32'hFF << (8 * (3 - k));
                wdat = (w & ~mask) | ((d & 32'hFF) << (8 * (3 - k)));
            end else begin
                mask = 32'hFFFF << (8 * (2 - k));
                wdat = (w & ~mask) | ((d & 32'hFFFF) << (8 * (2 - k)));
            end
            ref_mem[a[5:2]] = wdat;
        end
    endtask

    task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
        logic        e;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wdat;
        int          cyc;
        int          rd_got;
        int          wr_got;
        int          lat_got;
        bit          seen;
        logic        err_got;
        logic [31:0] ld_got;
        model(o, a, d, e, lat, nrd, nwr, wdat);
        @(negedge clk);
        bus.req = 1'b1; bus.op = o; bus.addr = a; bus.store_data = d;
        #1;
        check("idle_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        cyc = 0; rd_got = 0; wr_got = 0; lat_got = 0; seen = 0; err_got = 1'b0; ld_got = 32'h0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_rd) rd_got++;
            if (bus.mem_wr) wr_got++;
            if (bus.mem_rd && bus.mem_wr) check("strobe_excl", 32'd1, 32'd0);
            if (bus.busy) check("busy_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
            if (bus.mem_wr) check("wr_data", bus.mem_wr_data, wdat);
            if (bus.done) begin
                seen = 1; lat_got = cyc; err_got = bus.err; ld_got = bus.load_data;
            end
            if (cyc == 1) begin
                bus.req = 1'b0;
                bus.op = 3'($urandom_range(0, 7));
                bus.addr = $urandom;
                bus.store_data = $urandom;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        check("latency", 32'(lat_got), 32'(lat));
        check("err", {31'h0, err_got}, {31'h0, e});
        check("load_data", ld_got, ref_ld);
        check("rd_cycles", 32'(rd_got), 32'(nrd));
        check("wr_cycles", 32'(wr_got), 32'(nwr));
        check("mem_word", mem[a[5:2]], ref_mem[a[5:2]]);
    endtask

    initial begin
        logic        e;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wdat;
        logic [31:0] r;
        logic [5:0]  t_busy;
        logic [5:0]  t_done;
        logic [5:0]  t_rd;
        logic [5:0]  t_wr;
        int          wr_seen;
        n_vec = 0; n_miss = 0;
        clk = 1'b0; rst = 1'b1; mem_load = 1'b1;
        bus.req = 1'b1; bus.op = 3'd2; bus.addr = 32'hDEAD_BEEF; bus.store_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            seed_mem[i] = $urandom;
        end
        seed_mem[4] = 32'h8081_7F01;
        for (int i = 0; i < 16; i++) ref_mem[i] = seed_mem[i];
        ref_ld = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        check("rst_strobes", {30'h0, bus.mem_rd, bus.mem_wr}, 32'h0);
        check("rst_load_data", bus.load_data, 32'h0);
        check("rst_wr_data", bus.mem_wr_data, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        rst = 1'b0; mem_load = 1'b0; bus.req = 1'b0;

        access(3'd2, 32'h10, 32'h0);
        check("lw_value", bus.load_data, 32'h8081_7F01);
        access(3'd0, 32'h11, 32'h0);
        check("lb_value", bus.load_data, 32'hFFFF_FF81);
        access(3'd4, 32'h11, 32'h0);
        check("lbu_value", bus.load_data, 32'h0000_0081);
        access(3'd1, 32'h12, 32'h0);
        check("lh_value", bus.load_data, 32'h0000_7F01);
        access(3'd3, 32'h12, 32'h0000_00AA);
        check("sb_word", mem[4], 32'h8081_AA01);
        check("sb_keeps_ld", bus.load_data, 32'h0000_7F01);
        access(3'd2, 32'h13, 32'h0);
        access(3'd6, 32'h11, 32'h1234_5678);

        // Reset pulsed while an SH is in its read cycle
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'd6; bus.addr = 32'h10; bus.store_data = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        check("abort_in_rd", {31'h0, bus.mem_rd}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("abort_strobes", {30'h0, bus.mem_rd, bus.mem_wr}, 32'h0);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_mem_addr", bus.mem_addr, 32'h0);
        check("abort_load_data", bus.load_data, 32'h0);
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_wr) wr_seen++;
        end
        rst = 1'b0;
        ref_ld = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_wr) wr_seen++;
        end
        check("abort_no_write", 32'(wr_seen), 32'd0);
        check("abort_mem_word", mem[4], ref_mem[4]);
        access(3'd2, 32'h10, 32'h0);

        // Request held high across an LW then an SW
        model(3'd2, 32'h10, 32'h0, e, lat, nrd, nwr, wdat);
        model(3'd7, 32'h20, 32'hCAFE_F00D, e, lat, nrd, nwr, wdat);
        @(negedge clk);
        bus.req = 1'b1; bus.op = 3'd2; bus.addr = 32'h10; bus.store_data = 32'h0;
        @(posedge clk);
        t_busy = '0; t_done = '0; t_rd = '0; t_wr = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            t_busy[i] = bus.busy; t_done[i] = bus.done;
            t_rd[i] = bus.mem_rd; t_wr[i] = bus.mem_wr;
            if (i == 1) check("b2b_lw_data", bus.load_data, 32'h8081_AA01);
            if (i == 0) begin
                bus.op = 3'd7; bus.addr = 32'h20; bus.store_data = 32'hCAFE_F00D;
            end
            if (i == 4) bus.req = 1'b0;
        end
        check("b2b_busy", {26'h0, t_busy}, 32'b011011);
        check("b2b_done", {26'h0, t_done}, 32'b010010);
        check("b2b_rd", {26'h0, t_rd}, 32'b000001);
        check("b2b_wr", {26'h0, t_wr}, 32'b001000);
        check("b2b_excl", {26'h0, t_rd & t_wr}, 32'h0);
        check("b2b_mem", mem[8], ref_mem[8]);

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            access(3'($urandom_range(0, 7)), r, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
